scc_wave_sched: RTL and testbench
=================================

# scc_wave_sched

Time-multiplexed channel scheduler for the SCC/SCC+ sound path. It owns the five channel period counters and wave-table phase pointers. It shares a single registered wave-RAM read port and one multiply-accumulate unit among the five channels, and produces one mixed signed sample per mix round. It sits between the cartridge register decoder, which drives its register-write port, and the wave RAM plus audio mixer.

## Interface
Parameters:
- CHANNELS, 5, number of channels sequenced per round; fixed at 5 for SCC compatibility.
- OUT_W, 16, width of the mixed output sample.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  SCC tick (3.58 MHz enable); advances counters and requests a mix round.
- reg_we  in  1  register write strobe, one clk wide.
- reg_addr  in  4  0x0–0x9 period lo/hi per channel (ch = addr>>1, odd = hi); 0xA–0xE volume ch0–4; 0xF enable mask.
- reg_din  in  8  write data.
- sccplus_mode  in  1  0 = SCC (ch4 reads ch3 table), 1 = SCC+ (independent tables).
- ram_rd  out  1  wave-RAM read strobe.
- ram_addr  out  8  {table[2:0], phase[4:0]}.
- ram_data  in  8  signed wave byte, valid the clk after ram_rd.
- wave  out  OUT_W  signed mixed sample.
- wave_valid  out  1  one-clk pulse when wave updates.

## Operation
- Registers:
  - Period is 12 bits: lo byte plus hi[3:0]; hi[7:4] are ignored.
  - Volume is reg_din[3:0].
  - Enable mask is reg_din[4:0].
- Per channel, on each clk_en:
  - counter == 0: reload with period, phase = phase + 1 (5-bit, 31 wraps to 0).
  - Otherwise: counter decrements.
  - Result: one step every period+1 ticks.
- Period < 9: channel frozen. Phase holds, counter is held at period. The channel is still fetched and mixed at its held phase.
- Period write: the channel's counter reloads with the new period on the next clk_en. If a write and a reload land on the same clk, the written value is used.
- Volume or mask writes take effect for the next channel fetched, including mid-round.
- Table select: table = ch, except ch4 uses table 3 when sccplus_mode = 0.
- Scheduler FSM, states IDLE, FETCH(ch), ACC(ch), DONE:
  - IDLE: if start pending, clear acc, go to FETCH(0).
  - FETCH(ch): ram_rd = 1, ram_addr = {table, phase[ch]} (phase sampled this clk); go to ACC(ch).
  - ACC(ch): acc += enabled[ch] ? ram_data × volume[ch] : 0. The product is signed 8 × unsigned 4, giving a 12-bit signed value. Then go to FETCH(ch+1), or DONE after ch4.
  - DONE: wave = sign-extended acc, wave_valid = 1; go to IDLE.
- Accumulator width:
  - acc is 15-bit signed; range −9600..+9525, no saturation needed.
  - wave = acc sign-extended to OUT_W.
- Start requests:
  - Every clk_en sets the pending flag; it clears on entering FETCH(0).
  - clk_en arriving during a round is latched; multiple arrivals collapse into one round.
  - Counters never stall for the FSM.

## Timing
- Round length is 11 clks:
  - start at cycle 0 (IDLE sees pending);
  - FETCH/ACC pairs on cycles 1–10;
  - DONE on cycle 11, when wave/wave_valid are registered.
- Read handshake: ram_rd is high exactly on FETCH cycles; ram_data is sampled on the following ACC cycle. The RAM has a fixed 1-clk registered latency; there is no wait state.
- ram_addr holds its last value outside FETCH.
- Full-rate operation requires at least 12 clks between clk_en pulses; otherwise rounds lag, since pending requests collapse.
- Reset values:
  - all periods, volumes, enable mask, counters and phases = 0;
  - wave = 0, wave_valid = 0, ram_rd = 0, ram_addr = 0;
  - FSM = IDLE, pending = 0.
- Reset mid-round aborts the round with no wave_valid.

## Configuration
- SCC_SCHED_PHASE_RESET_EN defined: any period write (lo or hi) also clears that channel's phase to 0 on the same clk, overriding a simultaneous step.
- Undefined: period writes never touch phase.

## Test plan
- Reset, then mask = 0x01, vol0 = 15, period0 = 9, RAM table0 phase p holds p−16, one clk_en every 12 clks.
  - Required: phase0 steps every 10 clk_en.
  - Required: first wave = −240, wave_valid one clk wide, 11 clks after the first clk_en.
- sccplus_mode = 0, all channels enabled at vol 15, ch3 and ch4 phases equal.
  - Required: the FETCH(4) ram_addr upper bits = 3.
  - With sccplus_mode = 1: upper bits = 4.
- All five tables = −128, vol = 15, mask = 0x1F → wave = −9600. Tables = +127 → wave = +9525.
- Two clk_en pulses 3 clks apart → exactly one extra round follows. Counters advance twice.
- Period0 = 5 → phase0 never changes over 100 clk_en. Write period0 = 20 → steps every 21 clk_en.
- Reset asserted at FETCH(2) → next clk all outputs 0, FSM IDLE, no wave_valid. With SCC_SCHED_PHASE_RESET_EN, a period write at phase 17 → phase 0.

Source files
------------

// File: rtl/scc_wave_sched_if.sv
// Bundle of the scheduler's register-write, tick, wave-RAM read and mixed-sample signals.
// master = register decoder / RAM / mixer side, slave = scc_wave_sched.
interface scc_wave_sched_if #(
    parameter int OUT_W = 16
);
    logic                    clk_en;
    logic                    reg_we;
    logic [3:0]              reg_addr;
    logic [7:0]              reg_din;
    logic                    sccplus_mode;
    logic                    ram_rd;
    logic [7:0]              ram_addr;
    logic signed [7:0]       ram_data;
    logic signed [OUT_W-1:0] wave;
    logic                    wave_valid;

    modport master (
        output clk_en, reg_we, reg_addr, reg_din, sccplus_mode, ram_data,
        input  ram_rd, ram_addr, wave, wave_valid
    );

    modport slave (
        input  clk_en, reg_we, reg_addr, reg_din, sccplus_mode, ram_data,
        output ram_rd, ram_addr, wave, wave_valid
    );
endinterface

// File: rtl/scc_wave_sched.sv
// SCC/SCC+ five-channel scheduler: period counters, phase pointers and a shared fetch/MAC mix round.
// Optional macro SCC_SCHED_PHASE_RESET_EN: a period write also clears that channel's phase.
module scc_wave_sched #(
    parameter int CHANNELS = 5,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    scc_wave_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

    logic [11:0]         period    [CHANNELS];
    logic [11:0]         period_nx [CHANNELS];
    logic [3:0]          volume    [CHANNELS];
    logic [11:0]         count     [CHANNELS];
    logic [4:0]          phase     [CHANNELS];
    logic [CHANNELS-1:0] period_wr;
    logic [CHANNELS-1:0] reload;
    logic [4:0]          mask;

    state_t             state;
    logic [2:0]         ch;
    logic [2:0]         ch_next;
    logic               pending;
    logic signed [14:0] acc;
    logic signed [14:0] acc_nx;

    // Signed wave byte times unsigned 4-bit volume; |result| <= 1920 fits 12 bits.
    function automatic logic signed [11:0] mac_term(input logic signed [7:0] s, input logic [3:0] v);
        logic signed [12:0] p;
        p = s * $signed({1'b0, v});
        return p[11:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] widen(input logic signed [14:0] a);
        return OUT_W'(a);
    endfunction

    function automatic logic [2:0] table_sel(input logic [2:0] c, input logic plus);
        return (c == 3'd4 && !plus) ? 3'd3 : c;
    endfunction

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_nx[i] = period[i];
            period_wr[i] = 1'b0;
            if (bus.reg_we && bus.reg_addr == 4'(2 * i)) begin
                period_nx[i][7:0] = bus.reg_din;
                period_wr[i]      = 1'b1;
            end
            if (bus.reg_we && bus.reg_addr == 4'(2 * i + 1)) begin
                period_nx[i][11:8] = bus.reg_din[3:0];
                period_wr[i]       = 1'b1;
            end
        end
        ch_next = ch + 3'd1;
        acc_nx  = acc + (mask[ch] ? 15'(mac_term(bus.ram_data, volume[ch])) : 15'sd0);
    end

    // A written period is loaded on the next tick without stepping the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                period[i] <= '0;
                volume[i] <= '0;
                count[i]  <= '0;
                phase[i]  <= '0;
            end
            mask   <= '0;
            reload <= '0;
        end else begin
            if (bus.reg_we && bus.reg_addr == 4'hF)
                mask <= bus.reg_din[4:0];
            for (int i = 0; i < CHANNELS; i++) begin
                period[i] <= period_nx[i];
                if (bus.reg_we && bus.reg_addr == 4'(10 + i))
                    volume[i] <= bus.reg_din[3:0];
                reload[i] <= !bus.clk_en && (reload[i] || period_wr[i]);
                if (bus.clk_en) begin
                    if (reload[i] || period_wr[i] || period_nx[i] < 12'd9) begin
                        count[i] <= period_nx[i];
                    end else if (count[i] == '0) begin
                        count[i] <= period_nx[i];
                        phase[i] <= phase[i] + 5'd1;
                    end else begin
                        count[i] <= count[i] - 12'd1;
                    end
                end
`ifdef SCC_SCHED_PHASE_RESET_EN
                if (period_wr[i])
                    phase[i] <= '0;
`endif
            end
        end
    end

    // Mix round: IDLE -> (FETCH, ACC) x5 -> DONE; ticks during a round collapse into pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ch             <= '0;
            pending        <= 1'b0;
            acc            <= '0;
            bus.wave       <= '0;
            bus.wave_valid <= 1'b0;
            bus.ram_rd     <= 1'b0;
            bus.ram_addr   <= '0;
        end else begin
            bus.wave_valid <= 1'b0;
            bus.ram_rd     <= 1'b0;
            pending        <= bus.clk_en || (pending && state != IDLE);
            case (state)
                IDLE: begin
                    if (pending) begin
                        acc          <= '0;
                        ch           <= '0;
                        state        <= FETCH;
                        bus.ram_rd   <= 1'b1;
                        bus.ram_addr <= {table_sel(3'd0, bus.sccplus_mode), phase[0]};
                    end
                end
                FETCH: state <= ACC;
                ACC: begin
                    acc <= acc_nx;
                    if (ch == 3'(CHANNELS - 1)) begin
                        state          <= DONE;
                        bus.wave       <= widen(acc_nx);
                        bus.wave_valid <= 1'b1;
                    end else begin
                        ch           <= ch_next;
                        state        <= FETCH;
                        bus.ram_rd   <= 1'b1;
                        bus.ram_addr <= {table_sel(ch_next, bus.sccplus_mode), phase[ch_next]};
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scc_wave_sched.sv
// Directed bench for scc_wave_sched: register-driven scenarios with hand-computed expectations.
module tb_scc_wave_sched;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;
    int   wv_cnt = 0;
    int   base;
    int   fidx = 0;
    logic [7:0]        fa [5];
    logic signed [7:0] mem [256];

    scc_wave_sched_if #(.OUT_W(16)) bus();

    scc_wave_sched #(.CHANNELS(5), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Registered wave RAM with one clk of latency, plus fetch/pulse observers.
    always @(posedge clk) begin
        if (bus.ram_rd)
            bus.ram_data <= mem[bus.ram_addr];
        if (reset) begin
            fidx <= 0;
        end else if (bus.ram_rd) begin
            fa[fidx] <= bus.ram_addr;
            fidx     <= (fidx == 4) ? 0 : fidx + 1;
        end
        if (bus.wave_valid)
            wv_cnt <= wv_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.reg_we   = 1'b1;
        bus.reg_addr = a;
        bus.reg_din  = d;
        tick(1);
        bus.reg_we   = 1'b0;
    endtask

    task automatic pulse();
        bus.clk_en = 1'b1;
        tick(1);
        bus.clk_en = 1'b0;
    endtask

    // Tick then wait until the DONE cycle of the round it starts.
    task automatic round();
        pulse();
        tick(11);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic fill(input int lo, input int hi, input logic signed [7:0] v);
        for (int i = lo; i <= hi; i++) mem[i] = v;
    endtask

    task automatic ramp0();
        for (int p = 0; p < 32; p++) mem[p] = 8'(p - 16);
    endtask

    initial begin
        bus.clk_en = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_din = '0;
        bus.sccplus_mode = 1'b0;
        fill(0, 255, 8'sd0);
        reset = 1'b1;
        tick(2);
        chk("rst_wave", bus.wave, 0);
        chk("rst_wave_valid", bus.wave_valid, 0);
        chk("rst_ram_rd", bus.ram_rd, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_phase0", dut.phase[0], 0);
        reset = 1'b0;
        tick(1);

        // Single channel, period 9, ramp table
        ramp0();
        wr(4'hF, 8'h01); wr(4'hA, 8'h0F); wr(4'h0, 8'h09); wr(4'h1, 8'h00);
        pulse();
        tick(10);
        chk("first_wv_early", bus.wave_valid, 0);
        tick(1);
        chk("first_wv", bus.wave_valid, 1);
        chk("first_wave", bus.wave, -240);
        tick(1);
        chk("wv_width", bus.wave_valid, 0);
        for (int k = 2; k <= 10; k++) round();
        chk("phase_after10", dut.phase[0], 0);
        round();
        chk("phase_after11", dut.phase[0], 1);
        chk("wave_ph1", bus.wave, -225);
        for (int k = 12; k <= 21; k++) round();
        chk("phase_after21", dut.phase[0], 2);
        chk("wave_ph2", bus.wave, -210);

        // Table select, extremes and mask
        do_reset();
        fill(0, 159, -8'sd128);
        for (int c = 0; c < 5; c++) wr(4'(10 + c), 8'h0F);
        wr(4'hF, 8'h1F);
        bus.sccplus_mode = 1'b0;
        round();
        chk("wave_min", bus.wave, -9600);
        chk("scc_fetch4_table", fa[4][7:5], 3);
        chk("scc_fetch3_addr", fa[3], 8'h60);
        chk("scc_fetch0_addr", fa[0], 0);
        bus.sccplus_mode = 1'b1;
        fill(0, 159, 8'sd127);
        round();
        chk("wave_max", bus.wave, 9525);
        chk("plus_fetch4_table", fa[4][7:5], 4);
        wr(4'hF, 8'h1E);
        round();
        chk("wave_mask1e", bus.wave, 7620);
        wr(4'hF, 8'h1F);
        fill(0, 159, 8'sd0);
        fill(96, 127, 8'sd10);
        fill(128, 159, -8'sd20);
        bus.sccplus_mode = 1'b0;
        round();
        chk("wave_scc_shared", bus.wave, 300);
        bus.sccplus_mode = 1'b1;
        round();
        chk("wave_plus_indep", bus.wave, -150);
        bus.sccplus_mode = 1'b0;

        // Two ticks 3 clks apart collapse into one extra round
        do_reset();
        fill(0, 255, 8'sd0);
        ramp0();
        wr(4'hF, 8'h01); wr(4'hA, 8'h0F); wr(4'h0, 8'h09);
        base = wv_cnt;
        pulse();
        tick(2);
        pulse();
        tick(40);
        chk("collapse_rounds", wv_cnt - base, 2);
        chk("collapse_count0", dut.count[0], 8);
        chk("collapse_wave", bus.wave, -240);

        // Frozen period, then period 20
        do_reset();
        wr(4'hF, 8'h01); wr(4'hA, 8'h0F); wr(4'h0, 8'h05);
        for (int k = 0; k < 100; k++) begin pulse(); tick(1); end
        chk("frozen_phase", dut.phase[0], 0);
        chk("frozen_count", dut.count[0], 5);
        wr(4'h0, 8'h14);
        for (int k = 0; k < 21; k++) begin pulse(); tick(1); end
        chk("p20_after21", dut.phase[0], 0);
        pulse(); tick(1);
        chk("p20_after22", dut.phase[0], 1);
        for (int k = 0; k < 20; k++) begin pulse(); tick(1); end
        chk("p20_after42", dut.phase[0], 1);
        pulse();
        tick(30);
        chk("p20_after43", dut.phase[0], 2);
        chk("p20_wave", bus.wave, -210);

        // Reset during FETCH(2)
        base = wv_cnt;
        pulse();
        tick(5);
        chk("fetch2_ram_rd", bus.ram_rd, 1);
        chk("fetch2_ram_addr", bus.ram_addr, 8'h40);
        reset = 1'b1;
        tick(1);
        chk("midrst_ram_rd", bus.ram_rd, 0);
        chk("midrst_ram_addr", bus.ram_addr, 0);
        chk("midrst_wave", bus.wave, 0);
        chk("midrst_wave_valid", bus.wave_valid, 0);
        reset = 1'b0;
        tick(20);
        chk("midrst_no_round", wv_cnt - base, 0);

        // Period write at phase 17
        do_reset();
        wr(4'h0, 8'h09);
        for (int k = 0; k < 171; k++) begin pulse(); tick(1); end
        chk("phase17", dut.phase[0], 17);
        wr(4'h1, 8'h00);
`ifdef SCC_SCHED_PHASE_RESET_EN
        chk("period_wr_phase", dut.phase[0], 0);
`else
        chk("period_wr_phase", dut.phase[0], 17);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
